// File: rtl/doc_monitor_pkg.sv
// Shared definitions for the sysid check monitor.
//   state_e      : controller state encoding
//   AddrId/AddrTs: sysid word select values driven on avm_address
//   WaitCntW     : width of the per-read wait counter
package doc_monitor_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StRdId,
      StRdTs,
      StCmp,
      StDone
   } state_e;

   localparam logic AddrId = 1'b0;
   localparam logic AddrTs = 1'b1;

   localparam int unsigned WaitCntW = 16;

endpackage

// File: rtl/doc_monitor_wait_timer.sv
// Per-read wait counter for the sysid check monitor.
//   clock, reset_n : clock, synchronous active-low reset
//   clear          : zero the counter (pulsed on every state change of the owner)
//   stall          : read outstanding and slave asserting waitrequest
//   expired        : stall seen with the counter already at Timeout; read must be abandoned
module doc_monitor_wait_timer
   import doc_monitor_pkg::*;
#(
   parameter int unsigned Timeout = 255
) (
   input  logic clock,
   input  logic reset_n,
   input  logic clear,
   input  logic stall,
   output logic expired
);

   localparam logic [WaitCntW-1:0] Limit = WaitCntW'(Timeout);

   logic [WaitCntW-1:0] count_q, count_d;

   assign expired = stall && (count_q == Limit);

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (stall && !expired) begin
         // Saturates at Limit because expiry forces the owner to leave the read state.
         count_d = count_q + WaitCntW'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/doc_monitor_sysid_check.sv
// Reads the two sysid words over Avalon-MM, compares them against expected values and
// retries up to MAX_RETRY times. A check runs automatically after reset and on each start.
//   clock, reset_n           : clock, synchronous active-low reset
//   start                    : single-cycle check request (ignored while busy)
//   avm_address/avm_read     : Avalon-MM read master (address 0 = id, 1 = timestamp)
//   avm_readdata/waitrequest : Avalon-MM read response
//   busy, done               : check in progress / finished (done sticky until next start)
//   pass, fail_id, fail_ts   : outcome of the final attempt
//   timeout                  : final attempt abandoned by the wait timer
//   id_value, ts_value       : last captured sysid words
//   retry_count              : retries consumed by the current/last check
module doc_monitor_sysid_check
   import doc_monitor_pkg::*;
#(
   parameter logic [31:0] EXPECTED_ID = 32'd13709566,
   parameter logic [31:0] EXPECTED_TS = 32'd1431089092,
   parameter int unsigned TIMEOUT     = 255,
   parameter int unsigned MAX_RETRY   = 3
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   output logic        avm_address,
   output logic        avm_read,
   input  logic [31:0] avm_readdata,
   input  logic        avm_waitrequest,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic        fail_id,
   output logic        fail_ts,
   output logic        timeout,
   output logic [31:0] id_value,
   output logic [31:0] ts_value,
   output logic [1:0]  retry_count
);

   localparam logic [1:0] MaxRetry = 2'(MAX_RETRY);

   state_e      state_q, state_d;
   logic        boot_q;
   logic [1:0]  retry_q, retry_d;
   logic [31:0] id_q, id_d;
   logic [31:0] ts_q, ts_d;
   logic        pass_q, pass_d;
   logic        fail_id_q, fail_id_d;
   logic        fail_ts_q, fail_ts_d;
   logic        timeout_q, timeout_d;
   // Timeout flag of the attempt in flight; only published to timeout at the end.
   logic        att_to_q, att_to_d;

   logic        start_eff;
   logic        accept;
   logic        stall;
   logic        expired;
   logic        timer_clear;
   logic        id_ok;
   logic        ts_ok;
   logic        attempt_ok;

   // The cycle right after reset release behaves as a sampled start.
   assign start_eff  = start || boot_q;
   assign accept     = avm_read && !avm_waitrequest;
   assign stall      = avm_read && avm_waitrequest;
   assign timer_clear = (state_d != state_q);

   assign id_ok      = (id_q == EXPECTED_ID);
   assign ts_ok      = (ts_q == EXPECTED_TS);
   assign attempt_ok = !att_to_q && id_ok && ts_ok;

   doc_monitor_wait_timer #(
      .Timeout (TIMEOUT)
   ) u_wait_timer (
      .clock   (clock),
      .reset_n (reset_n),
      .clear   (timer_clear),
      .stall   (stall),
      .expired (expired)
   );

   always_comb begin
      avm_read    = (state_q == StRdId) || (state_q == StRdTs);
      avm_address = (state_q == StRdTs) ? AddrTs : AddrId;
      busy        = avm_read || (state_q == StCmp);
      done        = (state_q == StDone);
      pass        = pass_q;
      fail_id     = fail_id_q;
      fail_ts     = fail_ts_q;
      timeout     = timeout_q;
      id_value    = id_q;
      ts_value    = ts_q;
      retry_count = retry_q;
   end

   always_comb begin
      state_d   = state_q;
      retry_d   = retry_q;
      id_d      = id_q;
      ts_d      = ts_q;
      pass_d    = pass_q;
      fail_id_d = fail_id_q;
      fail_ts_d = fail_ts_q;
      timeout_d = timeout_q;
      att_to_d  = att_to_q;

      unique case (state_q)
         StIdle, StDone: begin
            if (start_eff) begin
               state_d   = StRdId;
               retry_d   = '0;
               pass_d    = 1'b0;
               fail_id_d = 1'b0;
               fail_ts_d = 1'b0;
               timeout_d = 1'b0;
               att_to_d  = 1'b0;
            end
         end
         StRdId: begin
            if (accept) begin
               id_d    = avm_readdata;
               state_d = StRdTs;
            end else if (expired) begin
               att_to_d = 1'b1;
               state_d  = StCmp;
            end
         end
         StRdTs: begin
            if (accept) begin
               ts_d    = avm_readdata;
               state_d = StCmp;
            end else if (expired) begin
               att_to_d = 1'b1;
               state_d  = StCmp;
            end
         end
         StCmp: begin
            if (!attempt_ok && (retry_q < MaxRetry)) begin
               retry_d  = retry_q + 2'd1;
               att_to_d = 1'b0;
               state_d  = StRdId;
            end else begin
               state_d   = StDone;
               pass_d    = attempt_ok;
               // A timed-out attempt reports only the timeout, never a compare failure.
               fail_id_d = !att_to_q && !id_ok;
               fail_ts_d = !att_to_q && !ts_ok;
               timeout_d = att_to_q;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q   <= StIdle;
         boot_q    <= 1'b1;
         retry_q   <= '0;
         id_q      <= '0;
         ts_q      <= '0;
         pass_q    <= 1'b0;
         fail_id_q <= 1'b0;
         fail_ts_q <= 1'b0;
         timeout_q <= 1'b0;
         att_to_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         boot_q    <= 1'b0;
         retry_q   <= retry_d;
         id_q      <= id_d;
         ts_q      <= ts_d;
         pass_q    <= pass_d;
         fail_id_q <= fail_id_d;
         fail_ts_q <= fail_ts_d;
         timeout_q <= timeout_d;
         att_to_q  <= att_to_d;
      end
   end

endmodule

// File: tb/tb_doc_monitor_sysid_check.sv
// Bench for doc_monitor_sysid_check: a default-parameter instance behind a configurable
// Avalon slave model, plus a TIMEOUT=4 instance whose slave never releases waitrequest.
// Expected outcomes are queued when a check is issued; monitors pop them on done rising.
module tb_doc_monitor_sysid_check;

   localparam logic [31:0] EXP_ID = 32'd13709566;
   localparam logic [31:0] EXP_TS = 32'd1431089092;

   typedef struct {
      logic        pass;
      logic        fid;
      logic        fts;
      logic        to;
      logic [1:0]  retry;
      logic [31:0] id;
      logic [31:0] ts;
   } exp_t;

   int checks = 0;
   int errors = 0;

   exp_t q1[$];
   exp_t q2[$];

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        avm_address, avm_read, busy, done, pass, fail_id, fail_ts, timeout;
   logic [31:0] rdata, id_value, ts_value;
   logic        wr;
   logic [1:0]  retry_count;

   logic        rst2_n = 1'b0;
   logic        start2 = 1'b0;
   logic        wr2 = 1'b1;
   logic [31:0] rdata2 = 32'h0;
   logic        avm_address2, avm_read2, busy2, done2, pass2, fail_id2, fail_ts2, timeout2;
   logic [31:0] id_value2, ts_value2;
   logic [1:0]  retry_count2;

   // Slave model controls (written by stimulus only) and state (written by slave only).
   int   stall_n = 0;
   logic id_zero = 1'b0;
   int   bad_ts_until = 0;
   int   stall_cnt = 0;
   int   ts_acc = 0;

   always #5 clock = ~clock;

   doc_monitor_sysid_check u_dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .start           (start),
      .avm_address     (avm_address),
      .avm_read        (avm_read),
      .avm_readdata    (rdata),
      .avm_waitrequest (wr),
      .busy            (busy),
      .done            (done),
      .pass            (pass),
      .fail_id         (fail_id),
      .fail_ts         (fail_ts),
      .timeout         (timeout),
      .id_value        (id_value),
      .ts_value        (ts_value),
      .retry_count     (retry_count)
   );

   doc_monitor_sysid_check #(
      .TIMEOUT (4)
   ) u_dut_to (
      .clock           (clock),
      .reset_n         (rst2_n),
      .start           (start2),
      .avm_address     (avm_address2),
      .avm_read        (avm_read2),
      .avm_readdata    (rdata2),
      .avm_waitrequest (wr2),
      .busy            (busy2),
      .done            (done2),
      .pass            (pass2),
      .fail_id         (fail_id2),
      .fail_ts         (fail_ts2),
      .timeout         (timeout2),
      .id_value        (id_value2),
      .ts_value        (ts_value2),
      .retry_count     (retry_count2)
   );

   assign wr    = avm_read && (stall_cnt < stall_n);
   assign rdata = avm_address ? ((ts_acc < bad_ts_until) ? 32'hDEADBEEF : EXP_TS)
                              : (id_zero ? 32'h0 : EXP_ID);

   always @(posedge clock) begin
      if (avm_read && wr) stall_cnt <= stall_cnt + 1;
      else                stall_cnt <= 0;
      if (avm_read && !wr && avm_address) ts_acc <= ts_acc + 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cmp_res(input string tag, input exp_t a, input exp_t e);
      chk({tag, ".pass"}, 32'(a.pass), 32'(e.pass));
      chk({tag, ".fail_id"}, 32'(a.fid), 32'(e.fid));
      chk({tag, ".fail_ts"}, 32'(a.fts), 32'(e.fts));
      chk({tag, ".timeout"}, 32'(a.to), 32'(e.to));
      chk({tag, ".retry_count"}, 32'(a.retry), 32'(e.retry));
      chk({tag, ".id_value"}, a.id, e.id);
      chk({tag, ".ts_value"}, a.ts, e.ts);
      chk({tag, ".exclusive"}, 32'(a.pass ^ (a.fid | a.fts | a.to)), 32'd1);
   endtask

   // Monitor for the main instance.
   initial begin
      logic prev;
      exp_t a, e;
      prev = 1'b0;
      forever begin
         @(negedge clock);
         if (done && !prev) begin
            if (q1.size() == 0) begin
               chk("sb1.pending", 32'(q1.size()), 32'd1);
            end else begin
               e = q1.pop_front();
               a = '{pass, fail_id, fail_ts, timeout, retry_count, id_value, ts_value};
               cmp_res("dut", a, e);
            end
         end
         prev = done;
      end
   end

   // Monitor for the timeout instance.
   initial begin
      logic prev;
      exp_t a, e;
      prev = 1'b0;
      forever begin
         @(negedge clock);
         if (done2 && !prev) begin
            if (q2.size() == 0) begin
               chk("sb2.pending", 32'(q2.size()), 32'd1);
            end else begin
               e = q2.pop_front();
               a = '{pass2, fail_id2, fail_ts2, timeout2, retry_count2, id_value2, ts_value2};
               cmp_res("dut_to", a, e);
            end
         end
         prev = done2;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   // Call at a negedge; leaves start asserted for exactly one rising edge.
   task automatic pulse_start();
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n;
      n = 0;
      while (!done && n < budget) begin
         @(negedge clock);
         n++;
      end
      chk({tag, ".done_within_budget"}, 32'(done), 32'd1);
   endtask

   initial begin
      // Reset state, both instances held in reset.
      repeat (3) @(negedge clock);
      chk("rst.avm_read", 32'(avm_read), 32'd0);
      chk("rst.avm_address", 32'(avm_address), 32'd0);
      chk("rst.busy", 32'(busy), 32'd0);
      chk("rst.done", 32'(done), 32'd0);
      chk("rst.pass", 32'(pass), 32'd0);
      chk("rst.retry_count", 32'(retry_count), 32'd0);
      chk("rst.id_value", id_value, 32'd0);
      chk("rst.ts_value", ts_value, 32'd0);

      // Boot auto-check, zero-wait slave.
      q1.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, EXP_ID, EXP_TS});
      q2.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 32'd0, 32'd0});
      reset_n = 1'b1;
      rst2_n  = 1'b1;
      @(negedge clock);
      chk("boot.s1.read", 32'(avm_read), 32'd1);
      chk("boot.s1.addr", 32'(avm_address), 32'd0);
      chk("boot.s1.busy", 32'(busy), 32'd1);
      @(negedge clock);
      chk("boot.s2.read", 32'(avm_read), 32'd1);
      chk("boot.s2.addr", 32'(avm_address), 32'd1);
      @(negedge clock);
      chk("boot.s3.read", 32'(avm_read), 32'd0);
      chk("boot.s3.busy", 32'(busy), 32'd1);
      chk("boot.s3.done", 32'(done), 32'd0);
      @(negedge clock);
      chk("boot.s4.done", 32'(done), 32'd1);
      chk("boot.s4.busy", 32'(busy), 32'd0);

      // Five stall cycles on each read; done exactly 14 cycles after start.
      stall_n = 5;
      repeat (2) @(negedge clock);
      q1.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, EXP_ID, EXP_TS});
      pulse_start();
      for (int s = 1; s <= 14; s++) begin
         if (s > 1) @(negedge clock);
         chk($sformatf("stall.s%0d.read", s), 32'(avm_read), 32'(s <= 12));
         chk($sformatf("stall.s%0d.addr", s), 32'(avm_address), 32'(s >= 7 && s <= 12));
         chk($sformatf("stall.s%0d.done", s), 32'(done), 32'(s == 14));
      end

      // Id word always wrong: four attempts, fail_id only.
      stall_n = 0;
      id_zero = 1'b1;
      @(negedge clock);
      q1.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 32'd0, EXP_TS});
      pulse_start();
      wait_done("badid", 100);
      id_zero = 1'b0;

      // Wrong timestamp on first attempt only; start must clear previous results.
      @(negedge clock);
      bad_ts_until = ts_acc + 1;
      q1.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 2'd1, EXP_ID, EXP_TS});
      pulse_start();
      chk("badts.s1.done", 32'(done), 32'd0);
      chk("badts.s1.fail_id", 32'(fail_id), 32'd0);
      chk("badts.s1.retry_count", 32'(retry_count), 32'd0);
      chk("badts.s1.id_retained", id_value, 32'd0);
      wait_done("badts", 100);

      // Reset during a stalled timestamp read; a start while busy is ignored.
      stall_n = 5;
      @(negedge clock);
      pulse_start();
      repeat (6) @(negedge clock);
      chk("rstmid.s7.addr", 32'(avm_address), 32'd1);
      pulse_start();
      chk("rstmid.s8.read", 32'(avm_read), 32'd1);
      chk("rstmid.s8.addr_held", 32'(avm_address), 32'd1);
      reset_n = 1'b0;
      @(negedge clock);
      chk("rstmid.avm_read", 32'(avm_read), 32'd0);
      chk("rstmid.busy", 32'(busy), 32'd0);
      chk("rstmid.ts_value", ts_value, 32'd0);
      stall_n = 0;
      @(negedge clock);
      q1.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, EXP_ID, EXP_TS});
      reset_n = 1'b1;
      @(negedge clock);
      wait_done("reboot", 20);

      // Drain both scoreboards (timeout instance may still be running).
      for (int n = 0; n < 200 && (q1.size() != 0 || q2.size() != 0); n++) @(negedge clock);
      chk("sb1.empty", 32'(q1.size()), 32'd0);
      chk("sb2.empty", 32'(q2.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
